updn_sweep_ctrl: RTL

Sweep sequencer for the 5-bit up/down counter. On a START command it loads the counter with a lower bound and sweeps it up to an upper bound and back down a programmed number of times. It issues load, enable and direction controls and monitors the counter's Q output. It sits between the control registers and the counter, so software only writes bounds and a sweep count.

---
 rtl/updn_sweep_ctrl_if.sv | 35 +++
 rtl/updn_sweep_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/updn_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer, its control registers and the
// 5-bit up/down counter. The slave modport is the sequencer's view; the
// master modport is the view of whatever drives commands and models the
// counter.
interface updn_sweep_ctrl_if #(
  parameter int WIDTH = 5
);
  // Control-register side
  logic             START;
  logic             ABORT;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] HI;
  logic [3:0]       SWEEPS;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [3:0]       SWEEP_CNT;

  // Counter side
  logic [WIDTH-1:0] Q;
  logic             LD;
  logic [WIDTH-1:0] LD_VAL;
  logic             CNT_EN;
  logic             U_D;

  modport slave (
    input  START, ABORT, LO, HI, SWEEPS, Q,
    output LD, LD_VAL, CNT_EN, U_D, BUSY, DONE, ERR, SWEEP_CNT
  );

  modport master (
    output START, ABORT, LO, HI, SWEEPS, Q,
    input  LD, LD_VAL, CNT_EN, U_D, BUSY, DONE, ERR, SWEEP_CNT
  );
endinterface

// File: rtl/updn_sweep_ctrl.sv
// Sweep sequencer for a 5-bit up/down counter. Loads the counter with the
// lower bound, then drives it up to the upper bound and back down a
// programmed number of times, watching the counter's Q for disturbances.
//
// Command semantics:
//   START is a level sampled at each rising edge and is only acted on in
//   IDLE. A valid START (LO<HI, SWEEPS!=0) is accepted at that edge and BUSY
//   rises for the following cycle; an invalid one yields a one-cycle ERR and
//   leaves all latched values alone. START seen in any other state is
//   dropped, never queued. ABORT is sampled the same way, acts only in
//   LOAD/UP/DOWN, wins over START, and returns to IDLE silently.
module updn_sweep_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  updn_sweep_ctrl_if.slave     bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [3:0]       r_rem;
  logic [3:0]       r_sweep_cnt;
  logic             r_err;

  logic w_start_ok;
  logic w_out_of_range;
  logic w_at_hi;
  logic w_at_lo;

  // Bound checks on the live counter value against the latched bounds.
  always_comb begin
    w_start_ok     = (bus.LO < bus.HI) && (bus.SWEEPS != 4'd0);
    w_at_hi        = (bus.Q == r_hi);
    w_at_lo        = (bus.Q == r_lo);
    w_out_of_range = (bus.Q < r_lo) || (bus.Q > r_hi);
  end

  // Sequencer state, latched bounds, sweep bookkeeping and the ERR pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_rem       <= 4'd0;
      r_sweep_cnt <= 4'd0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ABORT is meaningless here, so START is processed even with it.
          if (bus.START) begin
            if (w_start_ok) begin
              r_lo        <= bus.LO;
              r_hi        <= bus.HI;
              r_rem       <= bus.SWEEPS;
              r_sweep_cnt <= 4'd0;
              r_state     <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          r_state <= bus.ABORT ? S_IDLE : S_UP;
        end

        S_UP: begin
          if (bus.ABORT) begin
            r_state <= S_IDLE;
          end else if (w_out_of_range) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_at_hi) begin
            // The cycle spent here with CNT_EN low is the dwell at HI.
            r_state <= S_DOWN;
          end
        end

        S_DOWN: begin
          if (bus.ABORT) begin
            r_state <= S_IDLE;
          end else if (w_out_of_range) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_at_lo) begin
            // Dwell at LO closes one full up+down sweep.
            r_sweep_cnt <= r_sweep_cnt + 4'd1;
            r_rem       <= r_rem - 4'd1;
            r_state     <= (r_rem == 4'd1) ? S_DONE : S_UP;
          end
        end

        S_DONE: begin
          // START and ABORT are both ignored for this one cycle.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Counter controls and status decoded directly from the registered state,
  // so an ABORT or guard trip silences the counter from the very next edge.
  always_comb begin
    bus.LD        = 1'b0;
    bus.CNT_EN    = 1'b0;
    bus.U_D       = 1'b0;
    bus.BUSY      = 1'b0;
    bus.DONE      = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.LD   = 1'b1;
        bus.BUSY = 1'b1;
      end
      S_UP: begin
        bus.BUSY   = 1'b1;
        bus.U_D    = 1'b1;
        bus.CNT_EN = !w_at_hi;
      end
      S_DOWN: begin
        bus.BUSY   = 1'b1;
        bus.U_D    = 1'b0;
        bus.CNT_EN = !w_at_lo;
      end
      S_DONE: begin
        bus.DONE = 1'b1;
      end
      default: begin
        bus.LD = 1'b0;
      end
    endcase
  end

  // Registered values passed straight through.
  always_comb begin
    bus.LD_VAL    = r_lo;
    bus.ERR       = r_err;
    bus.SWEEP_CNT = r_sweep_cnt;
    o_dbg_state   = r_state;
  end

endmodule
